// File: rtl/mac_accumulator.sv
// Multiply-accumulate back end: sums COUNT products over a valid/ready stream and holds the result until consumed.
// Optional build macro MAC_SATURATE_EN clamps the accumulator on carry-out instead of wrapping.
module mac_accumulator #(
  parameter int ACC_W = 10,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       prod,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] count_r;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic [ACC_W:0]   next_s;

  // Returns {carry, new accumulator}; the carry bit drives the sticky overflow flag.
  function automatic logic [ACC_W:0] add_beat(input logic [ACC_W-1:0] acc,
                                               input logic [7:0]       p);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, p};
`ifdef MAC_SATURATE_EN
    if (sum[ACC_W]) begin
      sum = {1'b1, ACC_MAX};
    end else begin
      sum = sum;
    end
`endif
    return sum;
  endfunction

  // Candidate accumulator value for a beat accepted this cycle.
  always_comb begin
    next_s = add_beat(acc_r, prod);
  end

  // Accumulation FSM: rst over clr over handshakes; HOLD freezes the result until transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      count_r     <= CNT_ZERO;
      acc_r       <= ACC_ZERO;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (clr) begin
      state_r     <= IDLE;
      count_r     <= CNT_ZERO;
      acc_r       <= ACC_ZERO;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, ACCUM: begin
          if (in_valid) begin
            acc_r   <= next_s[ACC_W-1:0];
            ovf_r   <= ovf_r | next_s[ACC_W];
            count_r <= count_r + CNT_ONE;
            if (count_r == LAST_CNT) begin
              state_r     <= HOLD;
              out_valid_r <= 1'b1;
            end else begin
              state_r     <= ACCUM;
              out_valid_r <= 1'b0;
            end
          end else begin
            state_r <= state_r;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_r     <= IDLE;
            count_r     <= CNT_ZERO;
            acc_r       <= ACC_ZERO;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r     <= IDLE;
          count_r     <= CNT_ZERO;
          acc_r       <= ACC_ZERO;
          ovf_r       <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // in_ready is a pure state decode, so HOLD blocks new beats including the transfer cycle.
  assign in_ready  = (state_r != HOLD);
  assign out_valid = out_valid_r;
  assign acc_out   = acc_r;
  assign overflow  = ovf_r;

endmodule
